// File: rtl/wt_store_merge_buffer.sv
// Store write buffer between the LSU and a write-through data cache port.
// Merges byte-enabled stores to the same word into one unissued entry,
// issues entries in allocation order with tagged in-flight writes, retires
// them in order as acks free them, and reports load hazards and emptiness.
module wt_store_merge_buffer #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int TID_WIDTH  = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  st_valid_i,
  output logic                  st_ready_o,
  input  logic [ADDR_WIDTH-1:0] st_addr_i,
  input  logic [XLEN-1:0]       st_data_i,
  input  logic [XLEN/8-1:0]     st_be_i,
  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [XLEN-1:0]       mem_data_o,
  output logic [XLEN/8-1:0]     mem_be_o,
  output logic [TID_WIDTH-1:0]  mem_tid_o,
  input  logic                  mem_ack_i,
  input  logic [TID_WIDTH-1:0]  mem_ack_tid_i,
  input  logic [ADDR_WIDTH-1:0] ld_addr_i,
  output logic                  ld_hit_o,
  output logic                  empty_o
);

  localparam int NB = XLEN / 8;
  localparam int OB = $clog2(NB);
  localparam int WW = ADDR_WIDTH - OB;   // word address width
  localparam int PW = $clog2(DEPTH);     // ring index width (pointers carry one extra wrap bit)
  localparam int NT = 1 << TID_WIDTH;

  typedef enum logic [1:0] {
    ST_FREE,
    ST_PENDING,
    ST_INFLIGHT
  } ent_state_e;

  // Per-entry state (control, reset) and payload (not reset)
  ent_state_e           state_q [DEPTH];
  ent_state_e           state_d [DEPTH];
  logic [WW-1:0]        waddr_q [DEPTH];
  logic [WW-1:0]        waddr_d [DEPTH];
  logic [XLEN-1:0]      data_q  [DEPTH];
  logic [XLEN-1:0]      data_d  [DEPTH];
  logic [NB-1:0]        be_q    [DEPTH];
  logic [NB-1:0]        be_d    [DEPTH];
  logic [TID_WIDTH-1:0] tid_q   [DEPTH];
  logic [TID_WIDTH-1:0] tid_d   [DEPTH];

  // Ring pointers, free-TID pool and the request-hold latch
  logic [PW:0]          head_q, head_d;
  logic [PW:0]          iss_q, iss_d;
  logic [PW:0]          tail_q, tail_d;
  logic [NT-1:0]        pool_q, pool_d;
  logic                 hold_q, hold_d;
  logic [TID_WIDTH-1:0] hold_tid_q, hold_tid_d;

  // Decoded combinational signals
  logic [PW:0]          occ;
  logic                 full;
  logic [PW-1:0]        head_idx, iss_idx, tail_idx;
  logic [WW-1:0]        st_waddr, ld_waddr;
  logic                 merge_hit;
  logic [PW-1:0]        merge_idx;
  logic [TID_WIDTH-1:0] free_tid, req_tid;
  logic                 st_fire, grant, ack_ok, ack_found;
  logic [PW-1:0]        ack_idx;

  logic unused_lo_bits;
  assign unused_lo_bits = ^{st_addr_i[OB-1:0], ld_addr_i[OB-1:0]};

  // Occupancy, issue request, merge lookup, ack lookup and hazard check
  always_comb begin
    occ      = tail_q - head_q;
    full     = occ[PW];                 // occupancy never exceeds DEPTH
    empty_o  = (occ == '0);
    head_idx = head_q[PW-1:0];
    iss_idx  = iss_q[PW-1:0];
    tail_idx = tail_q[PW-1:0];
    st_waddr = st_addr_i[ADDR_WIDTH-1:OB];
    ld_waddr = ld_addr_i[ADDR_WIDTH-1:OB];

    // Lowest free TID; once a request is stalled its TID is frozen so an
    // ack returning a lower TID cannot change mem_tid_o under the request.
    free_tid = '0;
    for (int t = NT - 1; t >= 0; t--) begin
      if (pool_q[t]) free_tid = TID_WIDTH'(t);
    end
    req_tid = hold_q ? hold_tid_q : free_tid;

    mem_req_o  = (state_q[iss_idx] == ST_PENDING) && (|pool_q);
    mem_addr_o = {waddr_q[iss_idx], {OB{1'b0}}};
    mem_data_o = data_q[iss_idx];
    mem_be_o   = be_q[iss_idx];
    mem_tid_o  = req_tid;

    // The entry under request is frozen, so it is excluded from merging
    merge_hit = 1'b0;
    merge_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (state_q[i] == ST_PENDING && waddr_q[i] == st_waddr &&
          !(mem_req_o && PW'(i) == iss_idx)) begin
        merge_hit = 1'b1;
        merge_idx = PW'(i);
      end
    end

    st_ready_o = merge_hit || !full;
    st_fire    = st_valid_i && st_ready_o && (st_be_i != '0);
    grant      = mem_req_o && mem_gnt_i;

    // An ack only counts for a TID that is actually out of the pool
    ack_ok    = mem_ack_i && !pool_q[mem_ack_tid_i];
    ack_found = 1'b0;
    ack_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (state_q[i] == ST_INFLIGHT && tid_q[i] == mem_ack_tid_i) begin
        ack_found = 1'b1;
        ack_idx   = PW'(i);
      end
    end

    ld_hit_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (state_q[i] != ST_FREE && waddr_q[i] == ld_waddr) ld_hit_o = 1'b1;
    end
  end

  // Next state: store merge/allocate, grant, ack and retire all in one cycle
  always_comb begin
    state_d    = state_q;
    waddr_d    = waddr_q;
    data_d     = data_q;
    be_d       = be_q;
    tid_d      = tid_q;
    head_d     = head_q;
    iss_d      = iss_q;
    tail_d     = tail_q;
    pool_d     = pool_q;
    hold_d     = mem_req_o && !mem_gnt_i;
    hold_tid_d = req_tid;

    if (st_fire) begin
      if (merge_hit) begin
        for (int b = 0; b < NB; b++) begin
          if (st_be_i[b]) data_d[merge_idx][8*b +: 8] = st_data_i[8*b +: 8];
        end
        be_d[merge_idx] = be_q[merge_idx] | st_be_i;
      end else begin
        state_d[tail_idx] = ST_PENDING;
        waddr_d[tail_idx] = st_waddr;
        data_d[tail_idx]  = st_data_i;
        be_d[tail_idx]    = st_be_i;
        tail_d            = tail_q + (PW+1)'(1);
      end
    end

    if (grant) begin
      state_d[iss_idx] = ST_INFLIGHT;
      tid_d[iss_idx]   = req_tid;
      pool_d[req_tid]  = 1'b0;
      iss_d            = iss_q + (PW+1)'(1);
    end

    if (ack_ok) begin
      pool_d[mem_ack_tid_i] = 1'b1;
      if (ack_found) state_d[ack_idx] = ST_FREE;
    end

    // Retire uses the registered entry state, so an ack frees the slot one
    // edge before head can move past it.
    if (state_q[head_idx] == ST_FREE && head_q != iss_q) begin
      head_d = head_q + (PW+1)'(1);
    end
  end

  // Control registers, discarded immediately by reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) state_q[i] <= ST_FREE;
      head_q     <= '0;
      iss_q      <= '0;
      tail_q     <= '0;
      pool_q     <= '1;
      hold_q     <= 1'b0;
      hold_tid_q <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      iss_q      <= iss_d;
      tail_q     <= tail_d;
      pool_q     <= pool_d;
      hold_q     <= hold_d;
      hold_tid_q <= hold_tid_d;
    end
  end

  // Entry payload; only meaningful while the entry state is not FREE
  always_ff @(posedge clk_i) begin
    waddr_q <= waddr_d;
    data_q  <= data_d;
    be_q    <= be_d;
    tid_q   <= tid_d;
  end

`ifndef SYNTHESIS
  // Acks for writes dropped by a reset are expected once each; any other
  // ack for a TID that is not in flight is a memory-side protocol error.
  logic [NT-1:0] stale_tid_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stale_tid_q <= stale_tid_q | ~pool_q;
    end else if (mem_ack_i && pool_q[mem_ack_tid_i]) begin
      assert (stale_tid_q[mem_ack_tid_i])
        else $error("ack for unused tid %0d", mem_ack_tid_i);
      stale_tid_q[mem_ack_tid_i] <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_wt_store_merge_buffer.sv
// Bench for wt_store_merge_buffer: a table of per-cycle vectors for the
// single-store and merge flows, then hand-written multi-cycle sequences.
module tb_wt_store_merge_buffer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        st_valid_i;
  logic        st_ready_o;
  logic [31:0] st_addr_i;
  logic [31:0] st_data_i;
  logic [3:0]  st_be_i;
  logic        mem_req_o;
  logic        mem_gnt_i;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic [3:0]  mem_be_o;
  logic [1:0]  mem_tid_o;
  logic        mem_ack_i;
  logic [1:0]  mem_ack_tid_i;
  logic [31:0] ld_addr_i;
  logic        ld_hit_o;
  logic        empty_o;

  wt_store_merge_buffer #(
    .XLEN(32), .ADDR_WIDTH(32), .DEPTH(8), .TID_WIDTH(2)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .st_valid_i(st_valid_i), .st_ready_o(st_ready_o),
    .st_addr_i(st_addr_i), .st_data_i(st_data_i), .st_be_i(st_be_i),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_be_o(mem_be_o),
    .mem_tid_o(mem_tid_o), .mem_ack_i(mem_ack_i), .mem_ack_tid_i(mem_ack_tid_i),
    .ld_addr_i(ld_addr_i), .ld_hit_o(ld_hit_o), .empty_o(empty_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        sv;
    logic [31:0] sa;
    logic [31:0] sd;
    logic [3:0]  sb;
    logic        g;
    logic        a;
    logic [1:0]  at;
    logic [31:0] ld;
    logic        x_ready;
    logic        x_req;
    logic [31:0] x_addr;
    logic [31:0] x_data;
    logic [3:0]  x_be;
    logic [1:0]  x_tid;
    logic        x_hit;
    logic        x_empty;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input int sv, input logic [31:0] sa, input logic [31:0] sd,
                              input int sb, input int g, input int a, input int at,
                              input logic [31:0] ld, input int xr, input int xq,
                              input logic [31:0] xa, input logic [31:0] xd, input int xb,
                              input int xt, input int xh, input int xe);
    vec_t v;
    v.sv = sv[0]; v.sa = sa; v.sd = sd; v.sb = sb[3:0];
    v.g = g[0]; v.a = a[0]; v.at = at[1:0]; v.ld = ld;
    v.x_ready = xr[0]; v.x_req = xq[0]; v.x_addr = xa; v.x_data = xd;
    v.x_be = xb[3:0]; v.x_tid = xt[1:0]; v.x_hit = xh[0]; v.x_empty = xe[0];
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input int sv, input logic [31:0] sa, input logic [31:0] sd, input int sb,
                       input int g, input int a, input int at, input logic [31:0] ld);
    st_valid_i    = sv[0];
    st_addr_i     = sa;
    st_data_i     = sd;
    st_be_i       = sb[3:0];
    mem_gnt_i     = g[0];
    mem_ack_i     = a[0];
    mem_ack_tid_i = at[1:0];
    ld_addr_i     = ld;
    #1;
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic idle(input int g);
    drive(0, 0, 0, 0, g, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    idle(0);
    tick();
    rst_i = 1'b0;
  endtask

  task automatic chk_req(input string nm, input logic [31:0] addr, input int tid);
    chk({nm, "_req"}, 32'(mem_req_o), 32'd1);
    chk({nm, "_addr"}, mem_addr_o, addr);
    chk({nm, "_tid"}, 32'(mem_tid_o), 32'(tid));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single store, then ack and drain
    vq.push_back(mk(0, 0, 0, 0,                     0, 0, 0, 0,            1, 0, 0, 0, 0, 0, 0, 1));
    vq.push_back(mk(1, 32'h8000_0004, 32'hAABB_CCDD, 'hF, 1, 0, 0, 0,     1, 0, 0, 0, 0, 0, 0, 1));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 0, 32'h8000_0004,
                    1, 1, 32'h8000_0004, 32'hAABB_CCDD, 'hF, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h8000_0006, 1, 0, 0, 0, 0, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 1, 0, 32'h8000_0006, 1, 0, 0, 0, 0, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h8000_0006, 1, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h8000_0006, 1, 0, 0, 0, 0, 0, 0, 1));
    // Merge of two partial stores behind a stalled request
    vq.push_back(mk(1, 32'h200, 32'h1234_5678, 'hF, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1));
    vq.push_back(mk(1, 32'h100, 32'h0000_1111, 'h3, 0, 0, 0, 0,
                    1, 1, 32'h200, 32'h1234_5678, 'hF, 0, 0, 0));
    vq.push_back(mk(1, 32'h100, 32'h2222_0000, 'hC, 0, 0, 0, 0,
                    1, 1, 32'h200, 32'h1234_5678, 'hF, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 0, 32'h102,
                    1, 1, 32'h200, 32'h1234_5678, 'hF, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0,
                    1, 1, 32'h100, 32'h2222_1111, 'hF, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1));

    rst_i = 1'b1;
    idle(0);
    tick();
    tick();
    rst_i = 1'b0;

    foreach (vq[k]) begin
      drive(vq[k].sv, vq[k].sa, vq[k].sd, vq[k].sb, vq[k].g, vq[k].a, vq[k].at, vq[k].ld);
      chk($sformatf("v%0d_ready", k), 32'(st_ready_o), 32'(vq[k].x_ready));
      chk($sformatf("v%0d_req", k), 32'(mem_req_o), 32'(vq[k].x_req));
      chk($sformatf("v%0d_ldhit", k), 32'(ld_hit_o), 32'(vq[k].x_hit));
      chk($sformatf("v%0d_empty", k), 32'(empty_o), 32'(vq[k].x_empty));
      if (vq[k].x_req) begin
        chk($sformatf("v%0d_addr", k), mem_addr_o, vq[k].x_addr);
        chk($sformatf("v%0d_data", k), mem_data_o, vq[k].x_data);
        chk($sformatf("v%0d_be", k), 32'(mem_be_o), 32'(vq[k].x_be));
        chk($sformatf("v%0d_tid", k), 32'(mem_tid_o), 32'(vq[k].x_tid));
      end
      tick();
    end

    // Full buffer: new word blocked, merge still accepted, retire not anticipated
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1, 32'h1000 + 32'(4 * i), 32'(i), 'hF, 0, 0, 0, 0);
      chk($sformatf("full_fill%0d_ready", i), 32'(st_ready_o), 32'd1);
      tick();
    end
    drive(1, 32'h2000, 32'h99, 'hF, 0, 0, 0, 0);
    chk("full_newword_ready", 32'(st_ready_o), 32'd0);
    drive(1, 32'h100C, 32'hCAFE_0000, 'hC, 0, 0, 0, 0);
    chk("full_merge_ready", 32'(st_ready_o), 32'd1);
    tick();
    idle(1);
    chk_req("full_g0", 32'h1000, 0);
    tick();
    drive(1, 32'h2000, 32'h99, 'hF, 0, 1, 0, 0);
    chk("full_ackcyc_ready", 32'(st_ready_o), 32'd0);
    tick();
    drive(1, 32'h2000, 32'h99, 'hF, 0, 0, 0, 0);
    chk("full_retirecyc_ready", 32'(st_ready_o), 32'd0);
    tick();
    idle(0);
    chk("full_after_retire_ready", 32'(st_ready_o), 32'd1);
    chk_req("full_hold", 32'h1004, 1);
    tick();
    idle(1);
    chk_req("full_g1", 32'h1004, 1);
    tick();
    idle(1);
    chk_req("full_g2", 32'h1008, 0);
    tick();
    idle(1);
    chk_req("full_g3", 32'h100C, 2);
    chk("full_g3_data", mem_data_o, 32'hCAFE_0003);
    chk("full_g3_be", 32'(mem_be_o), 32'hF);
    tick();

    // TID exhaustion: four in flight, fifth waits for a returned TID
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h3000 + 32'(4 * i), 32'(i), 'hF, 1, 0, 0, 0);
      if (i == 0) chk("tid_first_req", 32'(mem_req_o), 32'd0);
      else chk_req($sformatf("tid_issue%0d", i - 1), 32'h3000 + 32'(4 * (i - 1)), i - 1);
      tick();
    end
    idle(1);
    chk("tid_exhausted_req", 32'(mem_req_o), 32'd0);
    tick();
    drive(0, 0, 0, 0, 1, 1, 2, 0);
    chk("tid_ackcyc_req", 32'(mem_req_o), 32'd0);
    tick();
    idle(1);
    chk_req("tid_reuse", 32'h3010, 2);
    tick();

    // Out-of-order acks: head waits for the oldest entry
    do_reset();
    drive(1, 32'h4000, 32'h1, 'hF, 1, 0, 0, 0);
    chk("ooo_c0_empty", 32'(empty_o), 32'd1);
    tick();
    drive(1, 32'h4004, 32'h2, 'hF, 1, 0, 0, 0);
    chk_req("ooo_g0", 32'h4000, 0);
    tick();
    idle(1);
    chk_req("ooo_g1", 32'h4004, 1);
    tick();
    idle(0);
    chk("ooo_inflight_req", 32'(mem_req_o), 32'd0);
    tick();
    drive(0, 0, 0, 0, 0, 1, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 32'h4004);
    chk("ooo_after_ack1_empty", 32'(empty_o), 32'd0);
    chk("ooo_freed_ldhit", 32'(ld_hit_o), 32'd0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 32'h4000);
    chk("ooo_after_ack1_empty2", 32'(empty_o), 32'd0);
    chk("ooo_oldest_ldhit", 32'(ld_hit_o), 32'd1);
    tick();
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    chk("ooo_ack0cyc_empty", 32'(empty_o), 32'd0);
    tick();
    idle(0);
    chk("ooo_m1_empty", 32'(empty_o), 32'd0);
    tick();
    idle(0);
    chk("ooo_m2_empty", 32'(empty_o), 32'd0);
    tick();
    idle(0);
    chk("ooo_m3_empty", 32'(empty_o), 32'd1);
    tick();

    // Load hazard, then asynchronous reset with writes in flight
    do_reset();
    drive(1, 32'h104, 32'h55, 'h1, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 32'h104);
    chk("hz_pending_ldhit", 32'(ld_hit_o), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 32'h108);
    chk("hz_otherword_ldhit", 32'(ld_hit_o), 32'd0);
    tick();
    drive(1, 32'h108, 32'h66, 'hF, 1, 0, 0, 0);
    chk_req("hz_g0", 32'h104, 0);
    tick();
    drive(1, 32'h10C, 32'h77, 'hF, 1, 0, 0, 0);
    chk_req("hz_g1", 32'h108, 1);
    tick();
    idle(1);
    chk_req("hz_g2", 32'h10C, 2);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 32'h10C);
    chk("hz_inflight_empty", 32'(empty_o), 32'd0);
    chk("hz_inflight_ldhit", 32'(ld_hit_o), 32'd1);
    rst_i = 1'b1;
    #1;
    chk("rst_async_empty", 32'(empty_o), 32'd1);
    chk("rst_async_ldhit", 32'(ld_hit_o), 32'd0);
    chk("rst_async_ready", 32'(st_ready_o), 32'd1);
    chk("rst_async_req", 32'(mem_req_o), 32'd0);
    tick();
    rst_i = 1'b0;
    drive(0, 0, 0, 0, 0, 1, 0, 32'h10C);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 32'h10C);
    chk("rst_lateack_empty", 32'(empty_o), 32'd1);
    chk("rst_lateack_ldhit", 32'(ld_hit_o), 32'd0);
    chk("rst_lateack_req", 32'(mem_req_o), 32'd0);
    tick();
    drive(1, 32'h600, 32'h88, 'hF, 1, 0, 0, 0);
    tick();
    idle(1);
    chk_req("rst_newstore", 32'h600, 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
